// File: rtl/crane_bus_pkg.sv
// Shared definitions for the crane core memory bus.
//   state_e   : responder FSM encoding (ST_IDLE / ST_WAIT / ST_RESP)
//   XLEN      : bus data width
//   STRB_W    : byte-enable width
//   addr_err  : address legality check (misaligned, below base, beyond depth)
package crane_bus_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Operands are zero-extended to 64 bits, so the range compare sees the unwrapped values.
  // When addr < base the wrapped index is meaningless, but the second term already flags it.
  function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] base,
                                    input logic [63:0] depth);
    logic [63:0] idx;
    idx = (addr - base) >> 2;
    return (addr[1:0] != 2'b00) || (addr < base) || (idx >= depth);
  endfunction

endpackage

// File: rtl/crane_sram_1rw.sv
// Single-port word RAM with byte write enables and a registered read.
// Ports:
//   clk   : rising-edge clock
//   en    : access enable (read always performed, write when we=1)
//   we    : write enable
//   be    : byte enables for the write
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, holds until the next enabled access
// Contents are not reset.
module crane_sram_1rw
  import crane_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [STRB_W-1:0] be,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < int'(STRB_W); b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/crane_mem_responder.sv
// Memory-side responder for the core's valid/ready load/store/fetch bus.
// Accepts one request at a time, services it from an internal word RAM and returns a
// response LATENCY cycles after the accept edge, with rsp_err for bad addresses.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/req_ready          : request handshake
//   req_addr/req_we/req_wdata/req_wstrb : request payload (byte address, store flag, data, strobes)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata/rsp_err            : load data (0 for stores/errors) and address error flag
module crane_mem_responder
  import crane_bus_pkg::*;
#(
  parameter int unsigned     ADDR_W      = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned     LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              pend_err_q, pend_err_d;
  logic              pend_we_q, pend_we_d;

  logic              accept;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic              sram_en;
  logic              sram_we;
  logic [XLEN-1:0]   sram_rdata;

  // Held low through reset even though the state register already reads ST_IDLE.
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  assign req_idx = IDX_W'((req_addr - BASE_ADDR) >> 2);
  assign req_err = addr_err(64'(req_addr), 64'(BASE_ADDR), 64'(DEPTH_WORDS));

  // The RAM access happens on the accept edge; its registered read is the first latency cycle.
  assign sram_en = accept;
  assign sram_we = accept && req_we && !req_err;

  crane_sram_1rw #(
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .be    (req_wstrb),
    .addr  (req_idx),
    .wdata (req_wdata),
    .rdata (sram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    pend_err_d  = pend_err_q;
    pend_we_d   = pend_we_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_WAIT;
          cnt_d      = CNT_INIT;
          pend_err_d = req_err;
          pend_we_d  = req_we;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pend_err_q;
          rsp_rdata_d = (pend_err_q || pend_we_q) ? '0 : sram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      pend_err_q  <= 1'b0;
      pend_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      pend_err_q  <= pend_err_d;
      pend_we_q   <= pend_we_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_crane_mem_responder.sv
// Bench for crane_mem_responder: instance 0 (LATENCY=1, base 0) and instance 1 (LATENCY=4,
// base 0x1000), both 64 words deep. A negedge monitor keeps a reference memory and a
// scoreboard queue per instance; expected responses are pushed at accept and compared while
// the DUT presents them.
module tb_crane_mem_responder;

  localparam int unsigned      DEPTH = 64;
  localparam logic [31:0]      BASE0 = 32'h0000_0000;
  localparam logic [31:0]      BASE1 = 32'h0000_1000;
  localparam int               LAT0  = 1;
  localparam int               LAT1  = 4;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        req_we    [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl    [2][DEPTH];
  logic [32:0] sb     [2][$];
  bit          vprev  [2];
  int          age    [2];
  bit          rnd_rr [2];

  crane_mem_responder #(
    .ADDR_W      (32),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE0),
    .LATENCY     (LAT0)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_addr  (req_addr[0]),
    .req_we    (req_we[0]),
    .req_wdata (req_wdata[0]),
    .req_wstrb (req_wstrb[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0])
  );

  crane_mem_responder #(
    .ADDR_W      (32),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE1),
    .LATENCY     (LAT1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_addr  (req_addr[1]),
    .req_we    (req_we[1]),
    .req_wdata (req_wdata[1]),
    .req_wstrb (req_wstrb[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit ref_err(input int d, input logic [31:0] a);
    logic [63:0] off;
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < base_of(d)) return 1'b1;
    off = 64'(a - base_of(d)) >> 2;
    return off >= 64'(DEPTH);
  endfunction

  // Reference model and scoreboard; everything observed at negedge, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sb[d].delete();
        vprev[d] = 1'b0;
      end else begin
        age[d]++;
        if (sb[d].size() != 0) chk("req_ready_busy", 64'(req_ready[d]), 64'd0);
        if (rsp_valid[d]) begin
          chk("outstanding", 64'(sb[d].size()), 64'd1);
          if (sb[d].size() != 0) begin
            chk("rsp_rdata", 64'(rsp_rdata[d]), 64'(sb[d][0][31:0]));
            chk("rsp_err", 64'(rsp_err[d]), 64'(sb[d][0][32]));
            if (!vprev[d]) chk("latency", 64'(age[d]), 64'(lat_of(d) + 1));
            if (rsp_ready[d]) void'(sb[d].pop_front());
          end
        end else begin
          chk("idle_rsp_zero", {31'd0, rsp_err[d], rsp_rdata[d]}, 64'd0);
        end
        vprev[d] = rsp_valid[d];
        if (req_valid[d] && req_ready[d]) begin
          bit          e;
          logic [31:0] idx;
          logic [31:0] exp;
          e   = ref_err(d, req_addr[d]);
          idx = (req_addr[d] - base_of(d)) >> 2;
          exp = 32'd0;
          if (!e) begin
            if (req_we[d]) begin
              for (int b = 0; b < 4; b++)
                if (req_wstrb[d][b]) mdl[d][idx[5:0]][8*b +: 8] = req_wdata[d][8*b +: 8];
            end else begin
              exp = mdl[d][idx[5:0]];
            end
          end
          sb[d].push_back({e, exp});
          age[d] = 0;
        end
      end
    end
  end

  task automatic tick(input int d, output bit acc);
    @(negedge clk);
    acc = req_valid[d] && req_ready[d];
    @(posedge clk);
    #1;
    if (rnd_rr[d]) rsp_ready[d] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_op(input int d, input logic [31:0] addr, input bit we,
                       input logic [31:0] wd, input logic [3:0] ws, input int dly);
    bit acc;
    int n;
    acc = 1'b0;
    for (int i = 0; i < dly; i++) tick(d, acc);
    req_addr[d]  = addr;
    req_we[d]    = we;
    req_wdata[d] = wd;
    req_wstrb[d] = ws;
    req_valid[d] = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      tick(d, acc);
      n++;
    end
    chk("accept_timeout", 64'(acc), 64'd1);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    bit acc;
    int n;
    n = 0;
    while (sb[d].size() != 0 && n < 500) begin
      tick(d, acc);
      n++;
    end
    chk("drain", 64'(sb[d].size()), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_addr[d]  = 32'd0;
      req_we[d]    = 1'b0;
      req_wdata[d] = 32'd0;
      req_wstrb[d] = 4'd0;
      rsp_ready[d] = 1'b1;
      rnd_rr[d]    = 1'b0;
      age[d]       = 0;
      vprev[d]     = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 64'(req_ready[d]), 64'd0);
      chk("rst_rsp", {31'd0, rsp_valid[d], rsp_err[d], rsp_rdata[d]}, 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;

    // 1: store then load
    do_op(0, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
    do_op(0, 32'h10, 1'b0, 32'h0, 4'h0, 0);
    drain(0);

    // 2: partial-strobe store merge, then an all-zero-strobe store that changes nothing
    do_op(0, 32'h20, 1'b1, 32'h1122_3344, 4'hF, 0);
    do_op(0, 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101, 1);
    do_op(0, 32'h20, 1'b0, 32'h0, 4'h0, 0);
    do_op(0, 32'h20, 1'b1, 32'hFFFF_FFFF, 4'b0000, 0);
    do_op(0, 32'h20, 1'b0, 32'h0, 4'h0, 0);
    drain(0);

    // 3: misaligned and out-of-range accesses; the bad store must not alias word 0
    do_op(0, 32'h00, 1'b1, 32'h0102_0304, 4'hF, 0);
    do_op(0, 32'h22, 1'b0, 32'h0, 4'h0, 0);
    do_op(0, 32'h100, 1'b0, 32'h0, 4'h0, 0);
    do_op(0, 32'h100, 1'b1, 32'h5A5A_5A5A, 4'hF, 0);
    do_op(0, 32'h00, 1'b0, 32'h0, 4'h0, 0);
    do_op(0, 32'hFC, 1'b1, 32'h7777_8888, 4'hF, 0);
    do_op(0, 32'hFC, 1'b0, 32'h0, 4'h0, 0);
    drain(0);

    // Instance 1: below-base error and last valid word
    do_op(1, 32'h0FFC, 1'b0, 32'h0, 4'h0, 0);
    do_op(1, 32'h10FC, 1'b1, 32'hC0DE_0001, 4'hF, 0);
    do_op(1, 32'h10FC, 1'b0, 32'h0, 4'h0, 0);
    do_op(1, 32'h1100, 1'b0, 32'h0, 4'h0, 0);
    do_op(1, 32'h1010, 1'b1, 32'h55AA_0FF0, 4'hF, 0);
    drain(1);

    // 4: LATENCY=4 with a stalled response
    rsp_ready[1] = 1'b0;
    do_op(1, 32'h1010, 1'b0, 32'h0, 4'h0, 0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", 64'(rsp_valid[1]), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("hs_req_ready_low", 64'(req_ready[1]), 64'd0);
    chk("hs_valid_high", 64'(rsp_valid[1]), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_hs_req_ready", 64'(req_ready[1]), 64'd1);
    chk("after_hs_valid", 64'(rsp_valid[1]), 64'd0);
    @(posedge clk); #1;

    // 5: reset while a store is in WAIT; the store stays committed
    do_op(0, 32'h40, 1'b1, 32'hCAFE_F00D, 4'hF, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(rsp_valid[0]), 64'd0);
    chk("midrst_req_ready", 64'(req_ready[0]), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_valid2", 64'(rsp_valid[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(0, 32'h40, 1'b0, 32'h0, 4'h0, 1);
    drain(0);

    // 6: fill the RAM, then random traffic with response back-pressure
    for (int i = 0; i < int'(DEPTH); i++) do_op(0, 32'(i * 4), 1'b1, $urandom, 4'hF, 0);
    drain(0);
    rnd_rr[0] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (r == 8) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else             a = 32'h100 + 32'($urandom_range(0, 63) * 4);
      do_op(0, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 2));
    end
    drain(0);
    rnd_rr[0] = 1'b0;
    rsp_ready[0] = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
